// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM states, latched frame config and the 100 MHz baud table.
// Pure declarations; no latency and no flow control.
package uart_pkg;
  localparam int CNT_W = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  typedef struct packed {
    logic [3:0] baud;
    logic       eight;
    logic       pen;
    logic       ohel;
  } frame_cfg_t;

  // Clocks per bit at 100 MHz; the unused high indices fall back to the fastest rate.
  localparam logic [CNT_W-1:0] BIT_TIME [16] = '{
    19'd333333, 19'd83333, 19'd41667, 19'd20833,
    19'd10417,  19'd5208,  19'd2604,  19'd1736,
    19'd868,    19'd434,   19'd217,   19'd109,
    19'd109,    19'd109,   19'd109,   19'd109
  };

  function automatic logic [CNT_W-1:0] bit_time(input logic [3:0] sel);
    return BIT_TIME[sel];
  endfunction
endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchronizer for an asynchronous input; resets high (line idle).
// Latency STAGES cycles; no flow control.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ff <= '1;
    else          ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: mid-bit sampling of 7/8-bit frames with optional parity; status held until rx_read.
// Status registers one cycle after the stop sample; no backpressure, an unread byte is overwritten (ovf).
module uart_rx_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic [3:0] baud_sel,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic       rx_busy
);
  import uart_pkg::*;

  logic             rxs;
  rx_state_e        state, state_nxt;
  frame_cfg_t       cfg;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       sr;
  logic             cnt_zero;
  logic [CNT_W-1:0] cfg_bt;
  logic [3:0]       last_idx;
  logic [7:0]       frame_data;
  logic             par_bit;
  logic             par_exp;
  logic             frame_perr;
  logic             ld_cfg, ld_full, shift, complete;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (rx),
    .q      (rxs)
  );

  assign cnt_zero   = (cnt == '0);
  assign cfg_bt     = bit_time(cfg.baud);
  assign last_idx   = (cfg.eight ? 4'd7 : 4'd6) + {3'b000, cfg.pen};
  assign frame_data = cfg.eight ? sr[7:0] : {1'b0, sr[6:0]};
  assign par_bit    = cfg.eight ? sr[8] : sr[7];
  assign par_exp    = cfg.ohel ? ~^frame_data : ^frame_data;
  assign frame_perr = cfg.pen & (par_bit != par_exp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_cfg    = 1'b0;
    ld_full   = 1'b0;
    shift     = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          state_nxt = ST_START;
          ld_cfg    = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          if (!rxs) begin
            state_nxt = ST_DATA;
            ld_full   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          shift   = 1'b1;
          ld_full = 1'b1;
          if (bit_idx == last_idx) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_zero) begin
          complete  = 1'b1;
          state_nxt = rxs ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    rx_busy = (state != ST_IDLE);
  end

  // Frame config is captured once at the falling edge so mid-frame input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg     <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
    end else if (ld_cfg) begin
      cfg     <= '{baud: baud_sel, eight: eight, pen: pen, ohel: ohel};
      cnt     <= (bit_time(baud_sel) >> 1) - CNT_W'(1);
      bit_idx <= '0;
      sr      <= '0;
    end else begin
      if (ld_full)       cnt <= cfg_bt - CNT_W'(1);
      else if (!cnt_zero) cnt <= cnt - CNT_W'(1);
      if (shift) begin
        sr[bit_idx] <= rxs;
        bit_idx     <= bit_idx + 4'd1;
      end
    end
  end

  // A completing frame takes priority over a simultaneous host read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (complete) begin
      rx_data <= frame_data;
      rxrdy   <= 1'b1;
      perr    <= frame_perr;
      ferr    <= ~rxs;
      ovf     <= rxrdy & ~rx_read;
    end else if (rx_read) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed plus randomized frame bench for uart_rx_engine; expectations come from a frame-level model.
module tb_uart_rx_engine;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] baud_sel = 4'd11;
  logic       eight = 1'b1;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic       rx_read = 1'b0;
  logic [7:0] rx_data;
  logic       rxrdy, perr, ferr, ovf, rx_busy;

  int checks = 0;
  int passes = 0;

  uart_rx_engine #(.SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .baud_sel(baud_sel),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .rx_read (rx_read),
    .rx_data (rx_data),
    .rxrdy   (rxrdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf),
    .rx_busy (rx_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int bt_of(input logic [3:0] sel);
    case (sel)
      4'd0:  return 333333;
      4'd1:  return 83333;
      4'd2:  return 41667;
      4'd3:  return 20833;
      4'd4:  return 10417;
      4'd5:  return 5208;
      4'd6:  return 2604;
      4'd7:  return 1736;
      4'd8:  return 868;
      4'd9:  return 434;
      4'd10: return 217;
      default: return 109;
    endcase
  endfunction

  // Line bits (start, data LSB first, optional parity, stop) and the parity verdict the host should see.
  task automatic build(input logic [7:0] d, input bit e, input bit p, input bit o,
                       input bit flip, input bit stopbad,
                       output logic [15:0] bits, output int len, output bit perr_exp);
    int nd;
    int ones;
    bit par;
    nd   = e ? 8 : 7;
    ones = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      bits[1+i] = d[i];
      if (d[i]) ones++;
    end
    len = 1 + nd;
    par = o ? (ones % 2 == 0) : (ones % 2 == 1);
    if (flip) par = ~par;
    if (p) begin
      bits[len] = par;
      len++;
    end
    bits[len] = ~stopbad;
    len++;
    perr_exp = p && (((ones + int'(par)) % 2 == 1) != o);
  endtask

  task automatic drive(input logic [15:0] bits, input int len, input int bt, input int ncyc,
                       input int read_at, input bit scramble);
    for (int c = 0; c < ncyc; c++) begin
      rx      = (c / bt < len) ? bits[c / bt] : 1'b1;
      rx_read = (c == read_at);
      if (scramble && c == bt) begin
        baud_sel = 4'($urandom);
        eight    = 1'($urandom);
        pen      = 1'($urandom);
        ohel     = 1'($urandom);
      end
      @(negedge clk);
    end
    rx      = 1'b1;
    rx_read = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit e, input bit p,
                           input bit o, input bit flip, input bit stopbad, input logic [3:0] sel,
                           input bit scramble, input bit exp_ovf, input bit coincide_read);
    logic [15:0] bits;
    int len;
    int bt;
    int read_at;
    bit perr_exp;
    baud_sel = sel;
    eight    = e;
    pen      = p;
    ohel     = o;
    bt = bt_of(sel);
    build(d, e, p, o, flip, stopbad, bits, len, perr_exp);
    // The stop sample lands half a bit plus (len-1) bits after the edge is seen through the synchronizer.
    read_at = coincide_read ? (SYNC + bt / 2 + (len - 1) * bt) : -1;
    drive(bits, len, bt, (len + 1) * bt, read_at, scramble);
    chk({tag, ".rxrdy"}, 8'(rxrdy), 8'd1);
    chk({tag, ".data"},  rx_data, e ? d : {1'b0, d[6:0]});
    chk({tag, ".perr"},  8'(perr), 8'(perr_exp));
    chk({tag, ".ferr"},  8'(ferr), 8'(stopbad));
    chk({tag, ".ovf"},   8'(ovf),  8'(exp_ovf));
  endtask

  task automatic host_read(input string tag);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    chk({tag, ".rd_rxrdy"}, 8'(rxrdy), 8'd0);
    chk({tag, ".rd_flags"}, {5'd0, perr, ferr, ovf}, 8'd0);
  endtask

  initial begin
    logic [7:0] d;
    // Reset held with a toggling line: no state may move.
    for (int i = 0; i < 50; i++) begin
      rx = 1'($urandom);
      @(negedge clk);
    end
    chk("rst.data",  rx_data, 8'h00);
    chk("rst.flags", {3'd0, rxrdy, perr, ferr, ovf, rx_busy}, 8'd0);
    rx = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle.flags", {3'd0, rxrdy, perr, ferr, ovf, rx_busy}, 8'd0);

    run_frame("a5", 8'hA5, 1, 0, 0, 0, 0, 4'd11, 0, 0, 0);
    host_read("a5");
    run_frame("p41ok", 8'h41, 0, 1, 1, 0, 0, 4'd11, 0, 0, 0);
    host_read("p41ok");
    run_frame("p41bad", 8'h41, 0, 1, 1, 1, 0, 4'd11, 0, 0, 0);
    host_read("p41bad");

    run_frame("f11", 8'h11, 1, 0, 0, 0, 0, 4'd11, 0, 0, 0);
    run_frame("f22", 8'h22, 1, 0, 0, 0, 0, 4'd11, 0, 1, 0);
    run_frame("f33", 8'h33, 1, 0, 0, 0, 0, 4'd11, 0, 0, 1);
    host_read("f33");

    // Short glitch: rejected at the start-bit check.
    baud_sel = 4'd11;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch.busy_hi", 8'(rx_busy), 8'd1);
    repeat (22) @(negedge clk);
    rx = 1'b1;
    repeat (218) @(negedge clk);
    chk("glitch.busy_lo", 8'(rx_busy), 8'd0);
    chk("glitch.rxrdy",   8'(rxrdy),   8'd0);

    // Line held low for three frame times: one framing-error byte, then parked until high.
    eight = 1'b1;
    pen   = 1'b0;
    rx    = 1'b0;
    repeat (3 * 10 * 109) @(negedge clk);
    chk("brk.rxrdy", 8'(rxrdy), 8'd1);
    chk("brk.ferr",  8'(ferr),  8'd1);
    chk("brk.data",  rx_data,   8'h00);
    chk("brk.ovf",   8'(ovf),   8'd0);
    chk("brk.busy",  8'(rx_busy), 8'd1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("brk.busy_lo", 8'(rx_busy), 8'd0);
    host_read("brk");
    repeat (300) @(negedge clk);
    chk("brk.no_second", 8'(rxrdy), 8'd0);

    // Reset in the middle of a data bit, with an unread byte pending.
    run_frame("f77", 8'h77, 1, 0, 0, 0, 0, 4'd11, 0, 0, 0);
    begin
      logic [15:0] bits;
      int len;
      bit pe;
      build(8'h5A, 1, 0, 0, 0, 0, bits, len, pe);
      drive(bits, len, 109, 4 * 109, -1, 0);
    end
    reset_n = 1'b0;
    #1;
    chk("midrst.data",  rx_data, 8'h00);
    chk("midrst.flags", {3'd0, rxrdy, perr, ferr, ovf, rx_busy}, 8'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (218) @(negedge clk);
    chk("midrst.idle", {3'd0, rxrdy, perr, ferr, ovf, rx_busy}, 8'd0);
    run_frame("f5a", 8'h5A, 1, 0, 0, 0, 0, 4'd11, 0, 0, 0);
    host_read("f5a");

    // Random configs; inputs are scrambled mid-frame to confirm the latched config is used.
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      run_frame($sformatf("rnd%0d", i), d, 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                4'(10 + $urandom_range(0, 5)), 1, 0, 0);
      host_read($sformatf("rnd%0d", i));
      repeat (20) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Receive engine for the UART peripheral: synchronizes the asynchronous serial RX line, recovers 7- or 8-bit frames with optional parity, and presents the received byte plus status flags to the UART register/port logic, which the TramelBlaze reads over its port bus. It sits between the board RX pin and the UART's input-port mux. The host acknowledges each byte with a one-cycle read pulse.

## Interface
Parameters:
- SYNC_STAGES, 2: flops in the RX synchronizer (≥2).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial input, idles high.
- baud_sel  in  4  baud index into BIT_TIME table.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  parity enable.
- ohel  in  1  parity sense: 1 = odd, 0 = even.
- rx_read  in  1  one-cycle pulse: host has read rx_data; clears status.
- rx_data  out  8  last received byte; bit 7 = 0 in 7-bit mode.
- rxrdy  out  1  byte available.
- perr  out  1  parity error on the byte in rx_data.
- ferr  out  1  framing error (stop bit sampled 0).
- ovf  out  1  a frame completed while rxrdy was already 1.
- rx_busy  out  1  high in any state other than IDLE.

## Operation
- rx passes through SYNC_STAGES flops (reset value 1); all logic uses the synchronized rxs.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: rxs == 0 → START; latch baud_sel, eight, pen, ohel into frame config; load counter with half bit time. Config changes mid-frame are ignored.
- START: at counter expiry sample rxs; 0 → DATA with full bit time; 1 → IDLE (false start, no flags touched).
- DATA: sample every full bit time, LSB first; data bits = eight ? 8 : 7, then one parity bit if pen. Then → STOP.
- STOP: sample after one bit time. Update rx_data, perr, ferr, rxrdy in the same cycle (see below). Stop == 1 → IDLE; stop == 0 → BREAK.
- BREAK: wait until rxs == 1, then → IDLE. A continuous low line yields exactly one frame with ferr = 1, rx_data = 0x00.
- perr = pen && (received parity != expected); expected = ohel ? ~^data : ^data over the received data bits only. perr = 0 when pen = 0.
- Frame completion: rx_data ← data, rxrdy ← 1, perr/ferr ← this frame's values; ovf ← 1 if rxrdy was 1 (new byte overwrites old).
- rx_read: clears rxrdy, perr, ferr, ovf. If rx_read and frame completion occur in the same cycle, completion wins: rxrdy = 1, new flags loaded, ovf = 0.
- Reset: state IDLE, rx_data = 0x00, rxrdy = perr = ferr = ovf = rx_busy = 0, counter = 0. Reset mid-frame discards the frame.

## Timing
- bit_time = BIT_TIME[baud_sel]; half = bit_time >> 1. Counter 19 bits, loads bit_time-1 and counts down to 0.
- Start validation sampled half bit time after the synchronized falling edge; each subsequent sample exactly bit_time cycles later.
- rxrdy rises the clk after the stop-bit sample (registered); end-to-end latency from rx stop-bit centre ≈ SYNC_STAGES + 1 cycles.
- rx_busy rises the cycle after rxs is first seen low; falls on return to IDLE.
- Back-to-back frames: a start bit beginning immediately after the stop bit centre is accepted (IDLE re-entered before the next falling edge).

## Structure
- Package uart_pkg: state enum; BIT_TIME[16] for 100 MHz: 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109 (indices 0–11), indices 12–15 = 109; counter width constant 19.
- Optional sub-module uart_sync (parameterized flop synchronizer, reset-high output), reusable by other UART input paths.

## Test plan
- Reset: hold reset_n = 0 with rx toggling → all outputs 0, rx_busy 0; release → idle, no false frame.
- baud_sel = 11, eight = 1, pen = 0, send 0xA5 → rxrdy = 1, rx_data = 0xA5, perr = ferr = ovf = 0; rx_read pulse → rxrdy = 0.
- eight = 0, pen = 1, ohel = 1, send 0x41 with correct odd parity → rx_data = 0x41, perr = 0; repeat with parity flipped → perr = 1.
- Two frames 0x11, 0x22 without rx_read → rx_data = 0x22, ovf = 1; rx_read coinciding with a completion → rxrdy = 1, ovf = 0.
- rx low for 0.3 bit time then high → no rxrdy, rx_busy returns 0; rx low for 3 frame times → one frame, ferr = 1, rx_data = 0x00, state stays BREAK until rx high.
- Assert reset_n low mid-DATA → outputs return to reset values immediately; next clean frame 0x5A received correctly.
